// File: rtl/if_pkg.sv
// if_pkg: shared fetch-stage types and encodings
package if_pkg;
    typedef enum logic {RUN, HALTED} fetch_state_t;
    localparam logic [3:0]  OPC_HALT  = 4'hF;
    localparam logic [15:0] NOP_INSTR = 16'h0000;
endpackage

// File: rtl/if_stage_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold, bubble and sync reset
module if_id_reg #(
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        bubble,
    input  logic [15:0] next_instr,
    input  logic [15:0] next_pc,
    input  logic        next_halt,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic        valid,
    output logic        halt
);
    always_ff @(posedge clk) begin
        if (rst) begin
            instr <= NOP_INSTR;
            pc    <= 16'h0000;
            valid <= 1'b0;
            halt  <= 1'b0;
        end else if (!hold) begin
            instr <= bubble ? NOP_INSTR : next_instr;
            pc    <= bubble ? pc : next_pc;
            valid <= !bubble;
            halt  <= !bubble && next_halt;
        end
    end
endmodule

// File: rtl/if_stage_unit.sv
// if_stage_unit: PC, fetch FSM and IF/ID register feeding decode
module if_stage_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = if_pkg::NOP_INSTR,
    parameter logic [3:0]  HALT_OPC  = if_pkg::OPC_HALT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_data,
    input  logic        imem_rdy,
    input  logic        data_hazard,
    input  logic        pc_hazard,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic        if_id_valid,
    output logic        if_id_halt,
    output logic        pc_update,
    output logic        fetch_halted
);
    import if_pkg::*;

    fetch_state_t state, state_next;
    logic [15:0]  pc, pc_next, pc_inc;
    logic         hold, bubble, is_halt, advance;

    always_comb begin
        pc_inc     = pc + 16'd1;
        is_halt    = imem_data[15:12] == HALT_OPC;
        hold       = !redirect_valid && (state == HALTED || data_hazard);
        bubble     = redirect_valid || pc_hazard || !imem_rdy;
        // a HALT word is latched but the PC stays on it
        advance    = !hold && imem_rdy && (pc_hazard || !is_halt);
        pc_next    = redirect_valid ? redirect_target : advance ? pc_inc : pc;
        state_next = redirect_valid ? RUN
                   : (!hold && !pc_hazard && imem_rdy && is_halt) ? HALTED : state;
        imem_addr    = pc;
        imem_req     = state == RUN && !rst;
        fetch_halted = state == HALTED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            state     <= RUN;
            pc_update <= 1'b0;
        end else begin
            pc        <= pc_next;
            state     <= state_next;
            pc_update <= redirect_valid;
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .bubble     (bubble),
        .next_instr (imem_data),
        .next_pc    (pc_inc),
        .next_halt  (is_halt),
        .instr      (if_id_instr),
        .pc         (if_id_pc),
        .valid      (if_id_valid),
        .halt       (if_id_halt)
    );
endmodule

// File: tb/tb_if_stage_unit.sv
// tb_if_stage_unit: directed plus random checks against a priority-rule model of the fetch stage
module tb_if_stage_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_rdy = 1'b0;
    logic        data_hazard = 1'b0;
    logic        pc_hazard = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_target = 16'h0000;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        if_id_halt;
    logic        pc_update;
    logic        fetch_halted;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc = 16'h0000, m_instr = 16'h0000, m_ipc = 16'h0000;
    logic        m_valid = 1'b0, m_halt = 1'b0, m_upd = 1'b0, m_halted = 1'b0;

    if_stage_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_req        (imem_req),
        .imem_data       (imem_data),
        .imem_rdy        (imem_rdy),
        .data_hazard     (data_hazard),
        .pc_hazard       (pc_hazard),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_valid     (if_id_valid),
        .if_id_halt      (if_id_halt),
        .pc_update       (pc_update),
        .fetch_halted    (fetch_halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the reference one clock using the documented priority order.
    task automatic model_edge();
        if (rst) begin
            m_pc = 16'h0000; m_halted = 1'b0; m_upd = 1'b0;
            m_instr = 16'h0000; m_ipc = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
        end else if (redirect_valid) begin
            m_pc = redirect_target; m_halted = 1'b0; m_upd = 1'b1;
            m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
        end else begin
            m_upd = 1'b0;
            if (m_halted || data_hazard) begin
            end else if (pc_hazard) begin
                m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
                if (imem_rdy) m_pc = m_pc + 16'd1;
            end else if (imem_rdy && imem_data[15:12] == 4'hF) begin
                m_instr = imem_data; m_valid = 1'b1; m_halt = 1'b1;
                m_ipc = m_pc + 16'd1; m_halted = 1'b1;
            end else if (imem_rdy) begin
                m_instr = imem_data; m_valid = 1'b1; m_halt = 1'b0;
                m_ipc = m_pc + 16'd1; m_pc = m_pc + 16'd1;
            end else begin
                m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic rdy, input logic [15:0] data,
                        input logic dh, input logic ph, input logic rv, input logic [15:0] tgt);
        rst = r; imem_rdy = rdy; imem_data = data;
        data_hazard = dh; pc_hazard = ph; redirect_valid = rv; redirect_target = tgt;
        @(posedge clk);
        model_edge();
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("imem_req", {15'd0, imem_req}, {15'd0, !m_halted && !rst});
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc", if_id_pc, m_ipc);
        chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
        chk("if_id_halt", {15'd0, if_id_halt}, {15'd0, m_halt});
        chk("pc_update", {15'd0, pc_update}, {15'd0, m_upd});
        chk("fetch_halted", {15'd0, fetch_halted}, {15'd0, m_halted});
    endtask

    initial begin
        step(1, 0, 16'h0000, 0, 0, 0, 16'h0000);
        step(1, 1, 16'h1111, 1, 1, 1, 16'h0033);
        step(0, 1, 16'h1234, 0, 0, 0, 16'h0000);
        step(0, 1, 16'h5678, 0, 0, 0, 16'h0000);
        step(0, 1, 16'h0000, 0, 0, 1, 16'h0005);
        step(0, 1, 16'hAAAA, 1, 0, 0, 16'h0000);
        step(0, 1, 16'hAAAB, 1, 1, 0, 16'h0000);
        step(0, 1, 16'h0BBB, 0, 0, 0, 16'h0000);
        step(0, 1, 16'h1111, 1, 0, 1, 16'h0040);
        step(0, 1, 16'h2222, 0, 0, 0, 16'h0000);
        step(0, 1, 16'h0000, 0, 0, 1, 16'h0007);
        step(0, 1, 16'hF000, 0, 0, 0, 16'h0000);
        step(0, 1, 16'h3333, 0, 0, 0, 16'h0000);
        step(0, 1, 16'h4444, 0, 1, 0, 16'h0000);
        step(0, 1, 16'h0000, 0, 0, 1, 16'h0010);
        step(0, 1, 16'h5555, 0, 0, 0, 16'h0000);
        repeat (3) step(0, 0, 16'h6666, 0, 0, 0, 16'h0000);
        step(0, 0, 16'h0000, 0, 0, 1, 16'h0009);
        step(0, 1, 16'h7777, 0, 1, 0, 16'h0000);
        step(0, 1, 16'h0000, 0, 0, 1, 16'hFFFF);
        step(0, 1, 16'h2222, 0, 0, 0, 16'h0000);
        step(0, 1, 16'h3456, 0, 0, 0, 16'h0000);
        step(1, 1, 16'h4567, 0, 0, 0, 16'h0000);
        for (int i = 0; i < 500; i++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 7) == 0) ? {4'hF, 12'($urandom)} : 16'($urandom);
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 d,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 11) == 0,
                 ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_stage_unit.md
Name: if_stage_unit

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Owns the PC and handshakes with instruction memory.
- Holds on data hazards, squashes on control hazards, and applies branch/call/ret redirects.
- Detects HALT at fetch and freezes fetch until a redirect resumes it.
- Drives the instruction, PC and valid fields consumed by decode.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0000, encoding inserted as a bubble
HALT_OPC, 4'hF, opcode (instr[15:12]) that halts fetch

Ports:
clk  in  1  global clock
rst  in  1  synchronous active-high reset
imem_addr  out  16  fetch address (always equals PC)
imem_req  out  1  fetch request
imem_data  in  16  instruction word, valid when imem_rdy=1
imem_rdy  in  1  memory returns data this cycle
data_hazard  in  1  decode stall: hold PC and IF/ID
pc_hazard  in  1  control hazard: squash the IF/ID contents to a bubble
redirect_valid  in  1  resolved branch/call/ret taken
redirect_target  in  16  new PC for a redirect
if_id_instr  out  16  instruction to decode
if_id_pc  out  16  PC+1 of that instruction (word addressed)
if_id_valid  out  1  IF/ID holds a real instruction
if_id_halt  out  1  IF/ID instruction is HALT
pc_update  out  1  one-cycle pulse: redirect applied this cycle
fetch_halted  out  1  FSM is in HALTED

Behaviour:
- All state updates on posedge clk; reset is synchronous, active high.
- Reset values:
  - PC=RESET_PC, state=RUN.
  - if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0, if_id_halt=0.
  - pc_update=0, fetch_halted=0.
- Combinational outputs: imem_addr=PC; imem_req=(state==RUN)&~rst.
- States: RUN, HALTED.
- Per-cycle priority, highest first; first match wins:
  1. rst: reset values above.
  2. redirect_valid:
     - PC<=redirect_target, IF/ID<=bubble, pc_update<=1, state<=RUN.
     - Applies in any state and overrides data_hazard; any in-flight imem_data is discarded.
  3. state==HALTED: PC and IF/ID hold; fetch_halted=1.
  4. data_hazard:
     - PC and all IF/ID fields hold; imem_data is discarded and refetched next cycle.
     - pc_hazard in the same cycle is ignored.
  5. pc_hazard: IF/ID<=bubble; PC<=PC+1 if imem_rdy, else PC holds.
  6. RUN & imem_rdy & imem_data[15:12]==HALT_OPC:
     - IF/ID<=imem_data with valid=1 and halt=1; PC holds; state<=HALTED.
  7. RUN & imem_rdy: IF/ID<=imem_data with valid=1; if_id_pc<=PC+1; PC<=PC+1.
  8. RUN & ~imem_rdy: IF/ID<=bubble; PC holds.
- Bubble means instr=NOP_INSTR, valid=0, halt=0; if_id_pc holds its value.
- pc_update is 1 only in the cycle after a rule-2 capture; otherwise 0.
- Latency: a word accepted at edge N appears on the IF/ID outputs after edge N; a redirect at edge N makes imem_addr=target in the same following cycle.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1=16'h0000, with no flag.
- Once captured, HALT stays in IF/ID while in HALTED; decode consumes it once (PC is frozen).

Decomposition:
- Shared package if_pkg:
  - Enum fetch_state_t {RUN, HALTED}.
  - Constants OPC_HALT and NOP_INSTR, also used by Control_Logic and the hazard unit.
- One sub-module: if_id_reg, holding the instr/pc/valid/halt fields with hold and bubble inputs and sync reset.
- The FSM and PC stay in if_stage_unit.

Test Plan:
- Reset then imem_rdy=1 every cycle, words 16'h1234, 16'h5678 → IF/ID shows 1234/pc=1, then 5678/pc=2, valid=1; imem_addr steps 0,1,2.
- data_hazard=1 for 2 cycles at PC=5 → PC stays 5 and IF/ID unchanged both cycles; after release, word at 5 enters IF/ID.
- redirect_valid=1, target=16'h0040, with data_hazard=1 in the same cycle → next cycle imem_addr=0x0040, if_id_valid=0, pc_update=1 for exactly one cycle.
- Fetch 16'hF000 at PC=7 → if_id_halt=1, fetch_halted=1, PC frozen at 7, imem_req=0. Then redirect to 0x0010 → state RUN, imem_addr=0x0010.
- imem_rdy=0 for 3 cycles → 3 bubbles (valid=0, instr=NOP_INSTR), PC unchanged. Plus pc_hazard=1 with imem_rdy=1 at PC=9 → bubble, PC=10.
- PC=16'hFFFF with word ready → PC wraps to 0, if_id_pc=0. rst asserted mid-run → all outputs at reset values at the next edge.
